// File: rtl/keypad_emulator_if.sv
// Command and scan-side signals of the keypad emulator.
// The master drives commands and the scanner row select; the slave is the emulator.
interface keypad_emulator_if;
    logic [2:0] sel;
    logic [2:0] column;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic [7:0] cmd_hold;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output sel,
        output cmd_valid,
        output cmd_key,
        output cmd_hold,
        input  column,
        input  cmd_ready,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  sel,
        input  cmd_valid,
        input  cmd_key,
        input  cmd_hold,
        output column,
        output cmd_ready,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/keypad_emulator.sv
// Emulates a 4x3 matrix keypad: queued key commands are pressed in step with the
// scanner's row select for a number of scan frames, then released for GAP_FRAMES frames.
module keypad_emulator #(
    parameter int DEPTH      = 4,
    parameter int GAP_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    keypad_emulator_if.slave kp
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int FRM_W = (GAP_FRAMES > 255) ? $clog2(GAP_FRAMES + 1) : 8;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
    localparam logic [FRM_W-1:0] GAP_LOAD = FRM_W'(GAP_FRAMES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_PRESS = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    // Returns {row, active-low column} for a key code.
    function automatic logic [5:0] key_decode(input logic [3:0] key);
        logic [5:0] rc;
        case (key)
            4'd0:    rc = {3'd3, 3'b101};
            4'd1:    rc = {3'd0, 3'b011};
            4'd2:    rc = {3'd0, 3'b101};
            4'd3:    rc = {3'd0, 3'b110};
            4'd4:    rc = {3'd1, 3'b011};
            4'd5:    rc = {3'd1, 3'b101};
            4'd6:    rc = {3'd1, 3'b110};
            4'd7:    rc = {3'd2, 3'b011};
            4'd8:    rc = {3'd2, 3'b101};
            4'd9:    rc = {3'd2, 3'b110};
            default: rc = {3'd7, 3'b111};
        endcase
        return rc;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [2:0]       sel_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]       tgt_row_q, tgt_row_d;
    logic [2:0]       tgt_col_q, tgt_col_d;
    logic [7:0]       hold_q, hold_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [3:0]       key_mem  [DEPTH];
    logic [7:0]       hold_mem [DEPTH];

    logic             frame_start;
    logic             cmd_ready_w;
    logic             key_ok;
    logic             push_hs;
    logic             push_en;
    logic             pop_en;
    logic [5:0]       head_map;
    logic             press_hit;

    assign frame_start = (kp.sel == 3'd0) && (sel_q != 3'd0);
    assign cmd_ready_w = (count_q != OCC_FULL);
    assign key_ok      = (kp.cmd_key <= 4'd9);
    assign push_hs     = kp.cmd_valid && cmd_ready_w;
    assign push_en     = push_hs && key_ok;
    assign pop_en      = (state_q == ST_IDLE) && (count_q != '0);
    assign head_map    = key_decode(key_mem[rd_ptr_q]);

    // Command storage; invalid keys never reach it, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_en) begin
            key_mem[wr_ptr_q]  <= kp.cmd_key;
            hold_mem[wr_ptr_q] <= kp.cmd_hold;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + OCC_ONE;
            2'b01:   count_d = count_q - OCC_ONE;
            default: count_d = count_q;
        endcase
        err_d = push_hs && !key_ok;
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        tgt_row_d   = tgt_row_q;
        tgt_col_d   = tgt_col_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_en) begin
                    tgt_row_d = head_map[5:3];
                    tgt_col_d = head_map[2:0];
                    hold_d    = hold_mem[rd_ptr_q];
                    state_d   = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (frame_start) begin
                    state_d     = ST_PRESS;
                    frame_cnt_d = (hold_q == 8'd0) ? FRM_ONE : FRM_W'(hold_q);
                end
            end
            ST_PRESS: begin
                if (frame_start) begin
                    if (frame_cnt_q <= FRM_ONE) begin
                        state_d     = ST_GAP;
                        frame_cnt_d = GAP_LOAD;
                    end else begin
                        frame_cnt_d = frame_cnt_q - FRM_ONE;
                    end
                end
            end
            ST_GAP: begin
                // A zero count only occurs with GAP_FRAMES = 0: finish without waiting a frame.
                if (frame_cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (frame_start) begin
                    if (frame_cnt_q == FRM_ONE) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt_q - FRM_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 3'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_cnt_q <= '0;
            tgt_row_q   <= 3'd7;
            tgt_col_q   <= 3'b111;
            hold_q      <= 8'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= kp.sel;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_cnt_q <= frame_cnt_d;
            tgt_row_q   <= tgt_row_d;
            tgt_col_q   <= tgt_col_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Column follows the live row select so the key appears in the scanned row only.
    assign press_hit = (state_q == ST_PRESS) && (kp.sel == tgt_row_q);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_col
            assign kp.column[gi] = press_hit ? tgt_col_q[gi] : 1'b1;
        end
    endgenerate

    assign kp.cmd_ready = cmd_ready_w;
    assign kp.busy      = (state_q != ST_IDLE) || (count_q != '0);
    assign kp.done      = done_q;
    assign kp.err       = err_q;

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth in entries; power of two, minimum 2.
REQ-002 Parameter GAP_FRAMES, default 2: number of scan frames the keys stay released between commands.
REQ-003 clk  in  1  system clock (same ck domain as the row-scan counter).
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 sel  in  3  keypad row select from the scanner; counts 0..5 and wraps.
REQ-006 column  out  3  emulated keypad column lines; active-low; 3'b111 means no key.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-009 cmd_key  in  4  key code 0..9.
REQ-010 cmd_hold  in  8  number of full scan frames to hold the key; 0 is treated as 1.
REQ-011 busy  out  1  high when the state is not IDLE or the FIFO is non-empty.
REQ-012 done  out  1  one-cycle pulse when a command's gap completes.
REQ-013 err  out  1  one-cycle pulse, the cycle after a rejected push.

Function
REQ-014 Key map {row sel, column}:
- 1 = {0, 011}; 2 = {0, 101}; 3 = {0, 110}
- 4 = {1, 011}; 5 = {1, 101}; 6 = {1, 110}
- 7 = {2, 011}; 8 = {2, 101}; 9 = {2, 110}
- 0 = {3, 101}
REQ-015 Push:
- cmd_ready = FIFO not full.
- A handshake with cmd_key > 9 drops the entry and raises err.
- A handshake with a valid key stores {key, hold}.
REQ-016 Frame start: sel_q is a register holding the previous sel; frame_start = (sel == 0) and (sel_q != 0).
REQ-017 States: IDLE, ALIGN, PRESS, GAP.
REQ-018 IDLE: when the FIFO is non-empty, pop the head into the active registers (target row, target column, hold count) and go to ALIGN on the next cycle.
REQ-019 ALIGN: on frame_start, go to PRESS, with the frame counter loaded with max(hold, 1).
REQ-020 PRESS: decrement the counter on each frame_start; when frame_start arrives with the counter at 1, go to GAP with the counter loaded with GAP_FRAMES.
REQ-021 GAP: decrement the counter on each frame_start; when frame_start arrives with the counter at 1 (or on entry if GAP_FRAMES = 0), pulse done and go to IDLE.
REQ-022 A command pending in the FIFO is popped from IDLE on the cycle after done, so back-to-back commands have no idle frames beyond GAP_FRAMES plus alignment.
REQ-023 column is combinational from registered state and the live sel input: it equals target_col when state = PRESS and sel = target_row, otherwise 3'b111.
REQ-024 A push and a pop on the same cycle are both honoured; occupancy is unchanged.
REQ-025 Pointers wrap modulo DEPTH; occupancy is tracked with a counter of width log2(DEPTH)+1.
REQ-026 At most one key is ever asserted; column never holds two low bits at once.
REQ-027 cmd_hold = 255 holds for 255 frames with no overflow.

Reset
REQ-028 On rst, immediately (asynchronously):
- state = IDLE, FIFO empty, pointers and counters = 0;
- sel_q = 3'b000, done = 0, err = 0, column = 3'b111, busy = 0, cmd_ready = 1.
REQ-029 rst asserted during PRESS releases the key in the same cycle and discards all queued commands.
REQ-030 After rst deasserts, the first frame_start requires sel to leave 0 and return to 0.

Verification
REQ-031 Push key 8, hold 2, with sel cycling 0..5:
- after alignment, column = 101 whenever sel = 2, for exactly 2 frames, otherwise 111;
- done pulses once, GAP_FRAMES frames after release.
REQ-032 Push key 12 -> cmd_ready stays 1, err pulses one cycle later, FIFO stays empty, busy stays 0.
REQ-033 Push keys 4, 6, 2, 8 back-to-back with DEPTH = 4 while the first is active:
- cmd_ready drops after the FIFO fills;
- the keys are emitted in order 4, 6, 2, 8;
- exactly 4 done pulses.
REQ-034 Push key 0 with hold 0 -> column = 101 only when sel = 3, for exactly 1 frame.
REQ-035 Assert rst mid-PRESS of key 5 with 2 commands queued -> column = 111 in the same cycle, busy = 0, no done pulse, and no queued command emitted after release.
REQ-036 Push into a full FIFO on the same cycle the head is popped -> the entry is accepted only if cmd_ready was high, and occupancy is correct afterwards.
